// File: rtl/serial_word_receiver.sv
// serial_word_receiver
// Reassembles framed serial words (start, data, optional even parity, stop)
// into a parallel word, shifting in the same direction the transmitter used.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line idle, waiting for a sampled 0 (start bit)
// DATA   | shifting in WIDTH data bits, accumulating parity
// PARITY | sampling the even-parity bit (only when PARITY_EN=1)
// STOP   | sampling the stop bit, then publishing the word or an error
module serial_word_receiver #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             bit_valid_i,
  input  logic             serial_i,
  input  logic             msb_first_i,
  output logic [WIDTH-1:0] word_o,
  output logic             word_valid_o,
  output logic             frame_err_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_par;
  logic             r_perr;
  logic             r_msb;
  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_err;
  logic             w_sample;
  logic             w_frame_ok;

  // An abort takes priority over any bit strobe on the same edge.
  assign w_sample   = bit_valid_i && !clr_i;
  assign w_frame_ok = serial_i && !r_perr;

  // Shift direction follows the direction latched at the start bit.
  always_comb begin
    w_sr_shift = r_sr;
    if (r_msb) begin
      w_sr_shift = {r_sr[WIDTH-2:0], serial_i};
    end else begin
      w_sr_shift = {serial_i, r_sr[WIDTH-1:1]};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: advance only on sampled bits, abort returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (clr_i) begin
      w_state_nxt = S_IDLE;
    end else if (bit_valid_i) begin
      case (r_state)
        S_IDLE: begin
          if (!serial_i) begin
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: shift register, counter, parity and the registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr    <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
      r_msb   <= 1'b0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_sample) begin
        case (r_state)
          S_IDLE: begin
            if (!serial_i) begin
              r_cnt  <= '0;
              r_par  <= 1'b0;
              r_perr <= 1'b0;
              r_msb  <= msb_first_i;
            end
          end
          S_DATA: begin
            r_sr  <= w_sr_shift;
            r_par <= r_par ^ serial_i;
            r_cnt <= r_cnt + CNT_W'(1);
          end
          S_PARITY: begin
            r_perr <= serial_i ^ r_par;
          end
          S_STOP: begin
            if (w_frame_ok) begin
              r_word  <= r_sr;
              r_valid <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign word_o       = r_word;
  assign word_valid_o = r_valid;
  assign frame_err_o  = r_err;
  assign busy_o       = (r_state != S_IDLE);

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Deserializer that reassembles framed serial words into a WIDTH-bit parallel word.
- It is the receive end of the serial link driven by the team's load/shift register. The transmitter loads a word and shifts it out MSB-first (left) or LSB-first (right). This block shifts the bits back in the same direction.
- It checks start, parity and stop framing, then presents the word with a one-cycle valid pulse or flags a frame error.
- It sits between the serial link pins (already synchronised) and the word-level consumer logic.

Parameters:
- WIDTH, 4, data bits per frame; legal range is WIDTH >= 2.
- PARITY_EN, 1, 1 = an even-parity bit follows the data; 0 = no parity bit.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- clr_i  input  1  synchronous abort. Returns the block to IDLE and discards the partial frame.
- bit_valid_i  input  1  bit strobe. serial_i is sampled only on rising edges where this is 1.
- serial_i  input  1  serial data line.
- msb_first_i  input  1  1 = data arrives MSB-first; 0 = data arrives LSB-first.
- word_o  output  WIDTH  last correctly received word.
- word_valid_o  output  1  one-cycle pulse when word_o updates.
- frame_err_o  output  1  one-cycle pulse on a parity or stop error.
- busy_o  output  1  high while a frame is in progress.

Behaviour:
- Reset values: word_o=0, word_valid_o=0, frame_err_o=0, busy_o=0. Internal state: IDLE, shift register 0, bit counter 0, parity accumulator 0.
- rst is asserted asynchronously at any time, including mid-frame. The block returns to IDLE immediately and the partial frame is lost.
- Frame format: start bit (0), WIDTH data bits, parity bit (only if PARITY_EN=1), stop bit (1).
- Idle line is 1. Sampled 1s in IDLE are ignored.
- State machine: IDLE -> DATA -> PARITY -> STOP -> IDLE. With PARITY_EN=0, DATA goes directly to STOP.
- The state advances only on edges with bit_valid_i=1. With bit_valid_i=0, all state holds. Gaps of any length between bits are legal.
- IDLE:
  - On a sampled 0 (start bit): go to DATA.
  - Clear the bit counter and the parity accumulator.
  - Latch msb_first_i for the frame. Changes to msb_first_i mid-frame are ignored.
- DATA, per sampled bit:
  - MSB-first: sr <= {sr[WIDTH-2:0], bit}.
  - LSB-first: sr <= {bit, sr[WIDTH-1:1]}.
  - parity accumulator ^= bit; counter += 1.
  - The counter is $clog2(WIDTH+1) bits wide. When the WIDTH-th bit is sampled, leave DATA.
- PARITY: sample the parity bit. perr = (bit != XOR of data bits), i.e. even parity over data+parity. Then go to STOP.
- STOP: sample the stop bit, then go to IDLE in all cases. There is no break detection.
  - Stop=1 and perr=0: word_o <= sr and word_valid_o=1.
  - Otherwise: frame_err_o=1 and word_o holds its previous value.
- Output timing:
  - Both pulses are registered. If the stop bit is sampled at edge k, the pulse is high from edge k to edge k+1, exactly one cycle.
  - word_valid_o and frame_err_o are never high together.
- busy_o:
  - Equals (state != IDLE), driven from the state register.
  - It rises after the edge that samples the start bit and falls after the edge that samples the stop bit.
- A new start bit can be sampled on the first bit_valid_i edge after the stop edge. Back-to-back frames are supported.
- clr_i: the state goes to IDLE on the next edge with no valid or error pulse. word_o is unchanged. clr_i wins over a simultaneous bit_valid_i.
- Latency: the word is visible one clock after the stop-bit sample edge.

Test Plan:
1. MSB-first good frame, WIDTH=4, PARITY_EN=1. Send 0,1,0,1,1,1,1 (start, data 1011, parity 1, stop) with bit_valid_i held high.
   -> word_o=4'b1011, one-cycle word_valid_o, frame_err_o=0.
   -> busy_o high for exactly 6 cycles, from the edge after start to the stop edge.
2. LSB-first good frame. Arrival data 1,0,1,1 with parity 1 and stop 1.
   -> word_o=4'b1101 and word_valid_o pulses.
   -> Then toggle msb_first_i mid-frame during a second frame: the result is unaffected.
3. Parity error. After test 1, send data 1011 with parity 0.
   -> frame_err_o pulses once, word_valid_o=0, word_o stays 4'b1011.
4. Stop error. Send a good data/parity frame with stop=0.
   -> frame_err_o pulses, word_o is unchanged, busy_o=0 afterwards.
   -> An immediately following good frame 0,0,1,1,0,0,1 yields word_o=4'b0110.
5. Gaps and idle. Send 10 idle 1s, then a frame with 0-3 random bit_valid_i=0 cycles between bits.
   -> The result is identical to the ungapped frame and no pulses occur during idle.
6. Abort and reset.
   -> Assert clr_i on the cycle the 3rd data bit is valid: no pulses, busy_o=0 next cycle, the next frame is received correctly.
   -> Assert rst mid-frame, between clock edges: all outputs are 0 immediately and the next frame is received correctly.
